// File: rtl/mem_pkg.sv
// Shared constants for the cache-fill read protocol and the backing memory.
// Contents:
//   ADDR_W, DATA_W   byte-address and word widths of the memory port
//   MEM_LATENCY      default request-to-data_valid delay
//   BLOCK_WORDS/BYTES cache block geometry, shared with the cache fill FSM
//   word_index()     byte address -> word address (drops addr[0])
package mem_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned MEM_LATENCY = 4;
    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned BLOCK_BYTES = 16;

    // Full word address; callers keep as many low bits as they actually store.
    function automatic logic [ADDR_W-2:0] word_index(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:1];
    endfunction

endpackage

// File: rtl/mem_read_responder_if.sv
// Single-port memory request/response bundle.
// Signals:
//   enable, wr, addr, data_in   request side, driven by the requester (master)
//   data_out, data_valid        read return, driven by the memory (slave)
//   outstanding                 reads in flight, driven by the memory (slave)
interface mem_read_responder_if
    import mem_pkg::*;
#(
    parameter int unsigned AW = mem_pkg::ADDR_W,
    parameter int unsigned DW = mem_pkg::DATA_W
);
    logic          enable;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic [3:0]    outstanding;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, outstanding
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, outstanding
    );
endinterface

// File: rtl/mem_delay_pipe.sv
// Fixed-latency {valid, data} shift register; no stall, no back-pressure.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_data   slot entering the pipe this cycle
//   out_valid, out_data slot leaving the pipe LATENCY cycles later
module mem_delay_pipe #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);
    logic [LATENCY-1:0] valid_q;
    logic [DATA_W-1:0]  data_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int i = 1; i < int'(LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];
endmodule

// File: rtl/mem_read_responder.sv
// Word-addressed backing memory for the cache fill FSM. One request per cycle;
// reads return exactly LATENCY cycles later through a fully pipelined path.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (array is not reset)
//   bus         slave side of mem_read_responder_if: enable/wr/addr/data_in in,
//               data_out/data_valid/outstanding out
module mem_read_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = mem_pkg::ADDR_W,
    parameter int unsigned DATA_W    = mem_pkg::DATA_W,
    parameter int unsigned LATENCY   = mem_pkg::MEM_LATENCY,
    parameter int unsigned WORD_BITS = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    mem_read_responder_if.slave bus
);
    if (LATENCY < 1 || LATENCY > 8) begin : gen_bad_latency
        $error("mem_read_responder: LATENCY must be 1..8");
    end

    logic [DATA_W-1:0]    mem_q [2**WORD_BITS];
    logic [ADDR_W-2:0]    widx;
    logic [WORD_BITS-1:0] idx;
    logic                 rd_issue;
    logic                 wr_issue;
    logic [DATA_W-1:0]    rd_data;
    logic                 ret_valid;
    logic [DATA_W-1:0]    ret_data;
    logic [3:0]           outstanding_q;
    logic [3:0]           outstanding_d;
    logic                 unused_addr;

    assign widx        = word_index(bus.addr);
    assign idx         = widx[WORD_BITS-1:0];
    // Upper bits alias (array wraps); addr[0] selects a byte within the word.
    assign unused_addr = ^{bus.addr[0], widx[ADDR_W-2:WORD_BITS]};

    // Gating on enable keeps X on idle-cycle wr/addr out of all state.
    assign rd_issue = bus.enable && !bus.wr;
    assign wr_issue = bus.enable && bus.wr;
    assign rd_data  = rd_issue ? mem_q[idx] : '0;

    always_ff @(posedge clk) begin
        if (wr_issue) begin
            mem_q[idx] <= bus.data_in;
        end
    end

    // Data is captured at issue, so a later write cannot change a read in flight.
    mem_delay_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_issue),
        .in_data   (rd_data),
        .out_valid (ret_valid),
        .out_data  (ret_data)
    );

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({rd_issue, ret_valid})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign bus.data_valid  = ret_valid;
    assign bus.data_out    = ret_valid ? ret_data : '0;
    assign bus.outstanding = outstanding_q;
endmodule
